// File: rtl/pad_debounce_pkg.sv
// Shared definitions for the pad debouncer: FSM encoding and 48 MHz default timings.
package pad_debounce_pkg;

    localparam int unsigned CLK_HZ               = 48_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DFLT = CLK_HZ / 1000;   // 1 ms
    localparam int unsigned LONG_CYCLES_DFLT     = CLK_HZ / 2;      // 0.5 s

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_RELEASING = 2'd3
    } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous level; reset loads RST_VAL into both flops.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clki,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clki) begin
        if (!rstn) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pad_debounce.sv
// Debounces a raw pad level and emits press, release and long-press pulses.
module pad_debounce
    import pad_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DFLT,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clki,
    input  logic rstn,
    input  logic pad_i,
    output logic pressed_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned LONG_W = $clog2(LONG_CYCLES) + 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);

    logic              pad_sync;
    logic              active_c;
    state_e            state_q,    state_nxt;
    logic [DEB_W-1:0]  deb_cnt_q,  deb_cnt_nxt;
    logic [LONG_W-1:0] long_cnt_q, long_cnt_nxt;
    logic              pressed_nxt, press_nxt, release_nxt, long_nxt;

    // Synchronizer resets to the idle pad level so reset never looks like a press.
    sync2 #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync2 (
        .clki (clki),
        .rstn (rstn),
        .d    (pad_i),
        .q    (pad_sync)
    );

    assign active_c = pad_sync ^ ACTIVE_LOW;

    always_ff @(posedge clki) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            deb_cnt_q  <= '0;
            long_cnt_q <= '0;
            pressed_o  <= 1'b0;
            press_o    <= 1'b0;
            release_o  <= 1'b0;
            long_o     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            deb_cnt_q  <= deb_cnt_nxt;
            long_cnt_q <= long_cnt_nxt;
            pressed_o  <= pressed_nxt;
            press_o    <= press_nxt;
            release_o  <= release_nxt;
            long_o     <= long_nxt;
        end
    end

    // Pulses are only raised on distinct transitions, so they are mutually exclusive.
    always_comb begin
        state_nxt    = state_q;
        deb_cnt_nxt  = deb_cnt_q;
        long_cnt_nxt = long_cnt_q;
        pressed_nxt  = pressed_o;
        press_nxt    = 1'b0;
        release_nxt  = 1'b0;
        long_nxt     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (active_c) begin
                    state_nxt   = ST_ARMING;
                    deb_cnt_nxt = '0;
                end
            end
            ST_ARMING: begin
                if (!active_c) begin
                    state_nxt = ST_IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_nxt    = ST_PRESSED;
                    pressed_nxt  = 1'b1;
                    press_nxt    = 1'b1;
                    long_cnt_nxt = '0;
                end else begin
                    deb_cnt_nxt = deb_cnt_q + DEB_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!active_c) begin
                    state_nxt   = ST_RELEASING;
                    deb_cnt_nxt = '0;
                end else if (long_cnt_q != LONG_MAX) begin
                    long_cnt_nxt = long_cnt_q + LONG_W'(1);
                    long_nxt     = (long_cnt_q == LONG_LAST);
                end
            end
            ST_RELEASING: begin
                // A bounce back to active resumes the press with the long count held.
                if (active_c) begin
                    state_nxt = ST_PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_nxt   = ST_IDLE;
                    pressed_nxt = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    deb_cnt_nxt = deb_cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pad_debounce.sv
// Directed bench for pad_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, active-low pad.
module tb_pad_debounce;

    logic clki;
    logic rstn;
    logic pad_i;
    logic pressed_o;
    logic press_o;
    logic release_o;
    logic long_o;

    int checks = 0;
    int errors = 0;

    pad_debounce #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clki      (clki),
        .rstn      (rstn),
        .pad_i     (pad_i),
        .pressed_o (pressed_o),
        .press_o   (press_o),
        .release_o (release_o),
        .long_o    (long_o)
    );

    initial clki = 1'b0;
    always #5 clki = ~clki;

    // Advance one rising edge and settle; inputs changed after this are sampled next edge.
    task automatic tick();
        @(posedge clki);
        #1;
    endtask

    task automatic test_reset();
        rstn  = 1'b0;
        pad_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({pressed_o, press_o, release_o, long_o} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold edge %0d: outputs got %b want 0000", i,
                         {pressed_o, press_o, release_o, long_o});
            end
        end
        rstn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (press_o !== (i == 7) || pressed_o !== (i >= 7) || release_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_release edge %0d: press %b pressed %b release %b want %b %b 0",
                         i, press_o, pressed_o, release_o, i == 7, i >= 7);
            end
        end
        pad_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (release_o !== (i == 7) || pressed_o !== (i < 7) || press_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_unpress edge %0d: release %b pressed %b press %b want %b %b 0",
                         i, release_o, pressed_o, press_o, i == 7, i < 7);
            end
        end
    endtask

    task automatic test_glitch();
        pad_i = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 3) pad_i = 1'b1;
            checks++;
            if (press_o !== 1'b0 || pressed_o !== 1'b0) begin
                errors++;
                $display("FAIL glitch edge %0d: press %b pressed %b want 0 0", i, press_o, pressed_o);
            end
        end
    endtask

    task automatic test_long_press();
        pad_i = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (press_o !== (i == 7) || pressed_o !== (i == 7)) begin
                errors++;
                $display("FAIL clean_press edge %0d: press %b pressed %b want %b %b",
                         i, press_o, pressed_o, i == 7, i == 7);
            end
        end
        for (int j = 1; j <= 40; j++) begin
            tick();
            checks++;
            if (long_o !== (j == 20) || press_o !== 1'b0 || pressed_o !== 1'b1
                || release_o !== 1'b0) begin
                errors++;
                $display("FAIL long_press +%0d: long %b press %b pressed %b release %b want %b 0 1 0",
                         j, long_o, press_o, pressed_o, release_o, j == 20);
            end
        end
        pad_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (release_o !== (i == 7) || long_o !== 1'b0 || pressed_o !== (i < 7)) begin
                errors++;
                $display("FAIL long_release edge %0d: release %b long %b pressed %b want %b 0 %b",
                         i, release_o, long_o, pressed_o, i == 7, i < 7);
            end
        end
    endtask

    task automatic test_release_bounce();
        pad_i = 1'b0;
        for (int i = 1; i <= 9; i++) tick();
        checks++;
        if (pressed_o !== 1'b1) begin
            errors++;
            $display("FAIL bounce_setup: pressed %b want 1", pressed_o);
        end
        // High for two sampled edges, low for four, then high for good.
        pad_i = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 2) pad_i = 1'b0;
            if (i == 6) pad_i = 1'b1;
            checks++;
            if (press_o !== 1'b0 || release_o !== 1'b0 || pressed_o !== 1'b1) begin
                errors++;
                $display("FAIL bounce edge %0d: press %b release %b pressed %b want 0 0 1",
                         i, press_o, release_o, pressed_o);
            end
        end
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (release_o !== (i == 7) || press_o !== 1'b0 || pressed_o !== (i < 7)) begin
                errors++;
                $display("FAIL bounce_release edge %0d: release %b press %b pressed %b want %b 0 %b",
                         i, release_o, press_o, pressed_o, i == 7, i < 7);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        pad_i = 1'b0;
        for (int i = 1; i <= 10; i++) tick();
        checks++;
        if (pressed_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: pressed %b want 1", pressed_o);
        end
        rstn = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if ({pressed_o, press_o, release_o, long_o} !== 4'b0000) begin
                errors++;
                $display("FAIL midreset_hold edge %0d: outputs got %b want 0000", i,
                         {pressed_o, press_o, release_o, long_o});
            end
        end
        rstn = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (press_o !== (i == 7) || pressed_o !== (i >= 7) || release_o !== 1'b0) begin
                errors++;
                $display("FAIL midreset_repress edge %0d: press %b pressed %b release %b want %b %b 0",
                         i, press_o, pressed_o, release_o, i == 7, i >= 7);
            end
        end
        pad_i = 1'b1;
        for (int i = 1; i <= 8; i++) tick();
        checks++;
        if (pressed_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_final: pressed %b want 0", pressed_o);
        end
    endtask

    initial begin
        rstn  = 1'b0;
        pad_i = 1'b1;
        test_reset();
        test_glitch();
        test_long_press();
        test_release_bounce();
        test_reset_mid_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pad_debounce.md
PAD_DEBOUNCE -- requirements
Module: pad_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 48000, sets the stable-level cycles required to accept a change (1 ms at 48 MHz clki).
REQ-002 Parameter LONG_CYCLES, default 24000000, sets the pressed cycles before the long-press event (0.5 s at 48 MHz).
REQ-003 Parameter ACTIVE_LOW, default 1: 1 means the pad reads 0 when pressed; 0 means it reads 1 when pressed.
REQ-004 clki  input  1  the single clock; all logic is rising-edge on clki.
REQ-005 rstn  input  1  reset, synchronous and active-low.
REQ-006 pad_i  input  1  raw asynchronous pad or button level (touch pad or contact pair).
REQ-007 pressed_o  output  1  debounced pressed level.
REQ-008 press_o  output  1  one-cycle pulse on an accepted press.
REQ-009 release_o  output  1  one-cycle pulse on an accepted release.
REQ-010 long_o  output  1  one-cycle pulse when a press has been held for LONG_CYCLES.

Function
REQ-011 pad_i SHALL pass through a 2-flop synchronizer, then be normalised so that active=1 per ACTIVE_LOW; the FSM uses only the normalised synchronized level.
REQ-012 The FSM SHALL have four states: IDLE, ARMING, PRESSED and RELEASING.
REQ-013 IDLE: when active=1, go to ARMING and clear the debounce counter.
REQ-014 ARMING: while active=1 the counter increments; if active=0, return to IDLE with no event (glitch rejected); when the counter reaches DEBOUNCE_CYCLES-1, go to PRESSED.
REQ-015 Entering PRESSED from ARMING SHALL, on that same edge, set pressed_o=1, pulse press_o for exactly one cycle and clear the long counter.
REQ-016 PRESSED: the long counter increments every cycle and saturates at LONG_CYCLES; long_o pulses exactly once, on the edge where the counter reaches LONG_CYCLES-1.
REQ-017 PRESSED: when active=0, go to RELEASING and clear the debounce counter; the long counter is held, not cleared.
REQ-018 RELEASING: while active=0 the debounce counter increments; at DEBOUNCE_CYCLES-1, go to IDLE, set pressed_o=0 and pulse release_o for one cycle.
REQ-019 RELEASING: if active=1 before the count completes, return to PRESSED with no press_o and with the long counter resuming from its held value.
REQ-020 Latency: a clean press SHALL produce press_o high exactly DEBOUNCE_CYCLES+3 cycles after the first clki edge that samples pad_i active; release latency is the same.
REQ-021 At most one of press_o, release_o and long_o SHALL be high in any cycle.
REQ-022 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES)+1 and long counter width $clog2(LONG_CYCLES)+1; neither counter may wrap.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 While rstn=0 at a clki edge: state=IDLE, both counters=0, both synchronizer flops=inactive level, pressed_o=0, press_o=0, release_o=0, long_o=0.
REQ-025 Reset asserted mid-press SHALL clear everything with no release_o pulse; a pad still held after reset deasserts SHALL be debounced afresh and produce a new press_o.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (2-bit, IDLE=0, ARMING=1, PRESSED=2, RELEASING=3) and the 48 MHz-derived default cycle constants.
REQ-027 The 2-flop synchronizer SHALL be a separate sub-module, sync2, reusable for other pad inputs; everything else stays in pad_debounce.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1)
REQ-028 Reset check: hold rstn=0 for 3 cycles with pad_i=0 -> all outputs 0 and no pulse until the pad has been active for 4+3 cycles after reset release.
REQ-029 Clean press: drive pad_i 1->0 and hold -> press_o pulses at cycle 7 after the first sampling edge, and pressed_o=1 from then on.
REQ-030 Glitch: pad_i low for 3 cycles then high -> no press_o and pressed_o stays 0.
REQ-031 Long press: hold pad_i low for 40 cycles -> exactly one long_o pulse, 20 cycles after press_o; no second pulse.
REQ-032 Release bounce: while pressed, pad_i high for 2 cycles, low again, then high for good -> no extra press_o, one release_o 7 cycles after the final rise, and pressed_o=0 afterwards.
REQ-033 Reset mid-press: assert rstn=0 while pressed_o=1 -> outputs cleared with no release_o; with pad still held, press_o recurs 7 cycles after reset release.
